// File: rtl/vis_bank_accumulator_if.sv
// Streaming bus bundle for vis_bank_accumulator.
// Input side: partial-sum entries (in_valid_i/in_last_i/in_re_i/in_im_i). There is no backpressure.
// Output side: accumulated frame stream with a valid/ready handshake (out_*).
// slave modport: used by the accumulator.
// master modport: used by the producer/consumer around it.
interface vis_bank_accumulator_if #(
  parameter int unsigned SBITS = 7,
  parameter int unsigned ACCUM = 36,
  parameter int unsigned BANKS = 2
);
  logic                     in_valid_i;
  logic                     in_last_i;
  logic [SBITS-1:0]         in_re_i;
  logic [SBITS-1:0]         in_im_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic                     out_last_o;
  logic [ACCUM-1:0]         out_re_o;
  logic [ACCUM-1:0]         out_im_o;
  logic [$clog2(BANKS)-1:0] out_bank_o;

  modport slave (
    input  in_valid_i, in_last_i, in_re_i, in_im_i, out_ready_i,
    output out_valid_o, out_last_o, out_re_o, out_im_o, out_bank_o
  );

  modport master (
    output in_valid_i, in_last_i, in_re_i, in_im_i, out_ready_i,
    input  out_valid_o, out_last_o, out_re_o, out_im_o, out_bank_o
  );
endinterface

// File: rtl/vis_bank_accumulator.sv
// Banked visibility accumulator.
// Sums TOTAL-entry blocks of signed partial visibilities over cfg_count_i blocks into a ring of
// BANKS frame banks. Completed banks are streamed out oldest-first.
// Ports:
//   vis_clock, reset_n   clock and synchronous active-low reset
//   cfg_count_i          blocks per frame (0 acts as 1), sampled at frame start
//   cfg_sat_i            saturating (1) or wrapping (0) add, sampled at frame start
//   clear_i              clears the sticky flags
//   bus                  input entries and output frame stream (slave modport)
//   frame_done_o         one-cycle pulse when a bank becomes full
//   overrun_o            sticky flag: an input entry was dropped
//   overflow_o           sticky flag: an accumulation exceeded the ACCUM range
//   sync_err_o           sticky flag: in_last_i was misaligned with the block
module vis_bank_accumulator #(
  parameter int unsigned TOTAL = 540,
  parameter int unsigned SBITS = 7,
  parameter int unsigned ACCUM = 36,
  parameter int unsigned BANKS = 2,
  parameter int unsigned NBITS = 16
) (
  input  logic                 vis_clock,
  input  logic                 reset_n,
  input  logic [NBITS-1:0]     cfg_count_i,
  input  logic                 cfg_sat_i,
  input  logic                 clear_i,
  vis_bank_accumulator_if.slave bus,
  output logic                 frame_done_o,
  output logic                 overrun_o,
  output logic                 overflow_o,
  output logic                 sync_err_o
);
  localparam int unsigned AW    = $clog2(TOTAL);
  localparam int unsigned BW    = $clog2(BANKS);
  localparam int unsigned DEPTH = BANKS * TOTAL;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned DW    = 2 * ACCUM;

  typedef enum logic {W_RUN, W_DROP} wr_state_t;

  // Flat RAM index of entry a in bank b.
  function automatic logic [IW-1:0] ram_idx(input logic [BW-1:0] b, input logic [AW-1:0] a);
    return IW'(b) * IW'(TOTAL) + IW'(a);
  endfunction

  // Step to the next bank in the ring.
  function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
    return (b == BW'(BANKS - 1)) ? '0 : b + 1'b1;
  endfunction

  // Signed add with optional clamp. Bit ACCUM of the result is the overflow indication.
  function automatic logic [ACCUM:0] acc_add(input logic [ACCUM-1:0] a, input logic [SBITS-1:0] b,
                                             input logic sat);
    logic [ACCUM:0]   s;
    logic             ovf;
    logic [ACCUM-1:0] r;
    s   = {a[ACCUM-1], a} + {{(ACCUM + 1 - SBITS){b[SBITS-1]}}, b};
    ovf = s[ACCUM] ^ s[ACCUM-1];
    r   = s[ACCUM-1:0];
    if (sat && ovf) r = s[ACCUM] ? {1'b1, {(ACCUM - 1){1'b0}}} : {1'b0, {(ACCUM - 1){1'b1}}};
    return {ovf, r};
  endfunction

  logic [DW-1:0] mem [DEPTH];

  wr_state_t        wr_state;
  logic [BW-1:0]    wr_bank;
  logic [AW-1:0]    wr_addr;
  logic [NBITS-1:0] blk_cnt, cnt_q;
  logic             sat_q;
  logic [BANKS-1:0] full;

  logic             s1_valid, s1_first, s1_end;
  logic [BW-1:0]    s1_bank;
  logic [IW-1:0]    s1_idx;
  logic [SBITS-1:0] s1_re, s1_im;
  logic [DW-1:0]    rmw_q;
  logic             s2_valid, s2_end;
  logic [BW-1:0]    s2_bank;
  logic [IW-1:0]    s2_idx;
  logic [DW-1:0]    s2_data;
  logic             done_q;
  logic [BW-1:0]    done_bank;

  logic [BW-1:0]    iss_bank, fetch_bank, skid_bank, out_bank;
  logic [AW-1:0]    iss_addr;
  logic             fetch_valid, fetch_last, skid_valid, skid_last, out_valid, out_last;
  logic [DW-1:0]    fetch_data, skid_data, out_data;

  // Write-side decode for the entry presented this cycle.
  logic             at_end_addr, frame_start, frame_end, pop, free_now, wr_busy;
  logic             ovr_ev, sync_ev, take, ovf_ev, issue, iss_last;
  logic [NBITS-1:0] blk_next;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic [ACCUM:0]   add_re, add_im;
  logic [1:0]       occ;

  always_comb begin
    at_end_addr = wr_addr == AW'(TOTAL - 1);
    frame_start = (blk_cnt == '0) && (wr_addr == '0);
    blk_next    = blk_cnt + 1'b1;
    frame_end   = at_end_addr && (blk_next == cnt_q);
    pop         = out_valid && bus.out_ready_i;
    free_now    = pop && out_last;
    // A bank released by the reader in this very cycle already counts as free.
    wr_busy     = full[wr_bank] && !(free_now && (out_bank == wr_bank));
    ovr_ev      = bus.in_valid_i && (wr_state == W_RUN) && frame_start && wr_busy;
    sync_ev     = bus.in_valid_i && (wr_state == W_RUN) && !ovr_ev &&
                  (bus.in_last_i != at_end_addr);
    take        = bus.in_valid_i && (wr_state == W_RUN) && !ovr_ev && !sync_ev;
    wr_idx      = ram_idx(wr_bank, wr_addr);
    // The first block of a frame ignores the stale RAM contents.
    add_re      = acc_add(s1_first ? '0 : rmw_q[DW-1:ACCUM], s1_re, sat_q);
    add_im      = acc_add(s1_first ? '0 : rmw_q[ACCUM-1:0], s1_im, sat_q);
    ovf_ev      = s1_valid && (add_re[ACCUM] || add_im[ACCUM]);
    // Out register, skid register and the read in flight hold at most two entries.
    occ         = 2'(out_valid) + 2'(skid_valid) + 2'(fetch_valid) - 2'(pop);
    issue       = full[iss_bank] && (occ < 2'd2);
    iss_last    = iss_addr == AW'(TOTAL - 1);
    rd_idx      = ram_idx(iss_bank, iss_addr);
  end

  // Frame RAM: one write port (RMW stage 2), one accumulate read port and one stream read port.
  always_ff @(posedge vis_clock) begin
    if (s2_valid) mem[s2_idx] <= s2_data;
    if (take)     rmw_q <= mem[wr_idx];
    if (issue)    fetch_data <= mem[rd_idx];
  end

  always_ff @(posedge vis_clock) begin
    if (!reset_n) begin
      wr_state <= W_RUN;
      wr_bank <= '0; wr_addr <= '0; blk_cnt <= '0; cnt_q <= NBITS'(1); sat_q <= 1'b0;
      full <= '0;
      s1_valid <= 1'b0; s1_first <= 1'b0; s1_end <= 1'b0; s1_bank <= '0; s1_idx <= '0;
      s1_re <= '0; s1_im <= '0;
      s2_valid <= 1'b0; s2_end <= 1'b0; s2_bank <= '0; s2_idx <= '0; s2_data <= '0;
      done_q <= 1'b0; done_bank <= '0;
      iss_bank <= '0; iss_addr <= '0;
      fetch_valid <= 1'b0; fetch_last <= 1'b0; fetch_bank <= '0;
      skid_valid <= 1'b0; skid_last <= 1'b0; skid_bank <= '0; skid_data <= '0;
      out_valid <= 1'b0; out_last <= 1'b0; out_bank <= '0; out_data <= '0;
      frame_done_o <= 1'b0; overrun_o <= 1'b0; overflow_o <= 1'b0; sync_err_o <= 1'b0;
    end else begin
      // Writer: address/block tracking, frame abort on misalignment, drop on overrun.
      if (ovr_ev) begin
        if (!bus.in_last_i) wr_state <= W_DROP;
      end else if (sync_ev) begin
        wr_addr <= '0;
        blk_cnt <= '0;
      end else if (take) begin
        if (frame_start) begin
          cnt_q <= (cfg_count_i == '0) ? NBITS'(1) : cfg_count_i;
          sat_q <= cfg_sat_i;
        end
        if (at_end_addr) begin
          wr_addr <= '0;
          if (frame_end) begin
            blk_cnt <= '0;
            wr_bank <= bank_inc(wr_bank);
          end else begin
            blk_cnt <= blk_next;
          end
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
      // Dropping ends at a block boundary; the next entry retries the frame start.
      if (bus.in_valid_i && (wr_state == W_DROP) && bus.in_last_i) wr_state <= W_RUN;

      // Accumulate pipeline: read at accept, add, then write back.
      s1_valid <= take;
      s1_first <= blk_cnt == '0;
      s1_end   <= frame_end;
      s1_bank  <= wr_bank;
      s1_idx   <= wr_idx;
      s1_re    <= bus.in_re_i;
      s1_im    <= bus.in_im_i;
      s2_valid <= s1_valid;
      s2_end   <= s1_valid && s1_end;
      s2_bank  <= s1_bank;
      s2_idx   <= s1_idx;
      s2_data  <= {add_re[ACCUM-1:0], add_im[ACCUM-1:0]};
      done_q    <= s2_valid && s2_end;
      done_bank <= s2_bank;
      frame_done_o <= done_q;

      for (int unsigned b = 0; b < BANKS; b++) begin
        if (free_now && (out_bank == BW'(b))) full[b] <= 1'b0;
        if (done_q && (done_bank == BW'(b)))  full[b] <= 1'b1;
      end

      overrun_o  <= (overrun_o && !clear_i) || ovr_ev;
      sync_err_o <= (sync_err_o && !clear_i) || sync_ev;
      overflow_o <= (overflow_o && !clear_i) || ovf_ev;

      // Reader: issue addresses from the oldest full bank into the prefetch/skid pair.
      if (issue) begin
        iss_addr <= iss_last ? '0 : iss_addr + 1'b1;
        if (iss_last) iss_bank <= bank_inc(iss_bank);
      end
      fetch_valid <= issue;
      fetch_last  <= iss_last;
      fetch_bank  <= iss_bank;

      if (out_valid && !pop) begin
        if (fetch_valid) begin
          skid_valid <= 1'b1;
          skid_last  <= fetch_last;
          skid_bank  <= fetch_bank;
          skid_data  <= fetch_data;
        end
      end else if (skid_valid) begin
        out_valid  <= 1'b1;
        out_last   <= skid_last;
        out_bank   <= skid_bank;
        out_data   <= skid_data;
        skid_valid <= fetch_valid;
        skid_last  <= fetch_last;
        skid_bank  <= fetch_bank;
        skid_data  <= fetch_data;
      end else begin
        out_valid <= fetch_valid;
        if (fetch_valid) begin
          out_last <= fetch_last;
          out_bank <= fetch_bank;
          out_data <= fetch_data;
        end
      end
    end
  end

  assign bus.out_valid_o = out_valid;
  assign bus.out_last_o  = out_last;
  assign bus.out_bank_o  = out_bank;
  assign bus.out_re_o    = out_data[DW-1:ACCUM];
  assign bus.out_im_o    = out_data[ACCUM-1:0];
endmodule

// File: tb/tb_vis_bank_accumulator.sv
// Directed bench for vis_bank_accumulator (TOTAL=4, BANKS=2, ACCUM=8).
module tb_vis_bank_accumulator;
  localparam int unsigned TOTAL = 4;
  localparam int unsigned SBITS = 7;
  localparam int unsigned ACCUM = 8;
  localparam int unsigned BANKS = 2;
  localparam int unsigned NBITS = 16;
  localparam int unsigned HW    = 1 + $clog2(BANKS) + 2 * ACCUM;

  logic             vis_clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [NBITS-1:0] cfg_count = '0;
  logic             cfg_sat = 1'b0;
  logic             clear = 1'b0;
  logic             frame_done, overrun, overflow, sync_err;

  vis_bank_accumulator_if #(.SBITS(SBITS), .ACCUM(ACCUM), .BANKS(BANKS)) bus ();

  vis_bank_accumulator #(
    .TOTAL(TOTAL), .SBITS(SBITS), .ACCUM(ACCUM), .BANKS(BANKS), .NBITS(NBITS)
  ) dut (
    .vis_clock    (vis_clock),
    .reset_n      (reset_n),
    .cfg_count_i  (cfg_count),
    .cfg_sat_i    (cfg_sat),
    .clear_i      (clear),
    .bus          (bus),
    .frame_done_o (frame_done),
    .overrun_o    (overrun),
    .overflow_o   (overflow),
    .sync_err_o   (sync_err)
  );

  always #5 vis_clock = ~vis_clock;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output stream monitor, sampled on the falling edge.
  longint        q_re[$], q_im[$], q_cyc[$];
  int            q_last[$], q_bank[$];
  int            fd_cnt = 0;
  longint        cyc = 0;
  logic          stalled_q = 1'b0;
  logic [HW-1:0] held_q, cur;

  assign cur = {bus.out_last_o, bus.out_bank_o, bus.out_re_o, bus.out_im_o};

  always @(posedge vis_clock) cyc = cyc + 1;

  always @(negedge vis_clock) begin
    if (!reset_n) begin
      stalled_q = 1'b0;
    end else begin
      if (stalled_q) begin
        check_eq("stall_valid", longint'(bus.out_valid_o), 1);
        check_eq("stall_hold", longint'(cur), longint'(held_q));
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        q_re.push_back(longint'($signed(bus.out_re_o)));
        q_im.push_back(longint'($signed(bus.out_im_o)));
        q_last.push_back(int'(bus.out_last_o));
        q_bank.push_back(int'(bus.out_bank_o));
        q_cyc.push_back(cyc);
      end
      if (frame_done) fd_cnt++;
      stalled_q = bus.out_valid_o && !bus.out_ready_i;
      held_q    = cur;
    end
  end

  task automatic tick();
    @(posedge vis_clock);
    #1;
  endtask

  task automatic clr_q();
    q_re.delete(); q_im.delete(); q_last.delete(); q_bank.delete(); q_cyc.delete();
    fd_cnt = 0;
  endtask

  task automatic send(input int re, input int im, input logic last);
    bus.in_valid_i = 1'b1;
    bus.in_last_i  = last;
    bus.in_re_i    = SBITS'(re);
    bus.in_im_i    = SBITS'(im);
    tick();
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
  endtask

  task automatic send_frame(input int nblk, input int re, input int im);
    for (int b = 0; b < nblk; b++)
      for (int e = 0; e < int'(TOTAL); e++) send(re, im, e == int'(TOTAL) - 1);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    bus.out_ready_i = 1'b1;
    cfg_sat = 1'b0;
    clear = 1'b0;
    tick();
    tick();
    check_eq({tag, "_rst_valid"}, longint'(bus.out_valid_o), 0);
    check_eq({tag, "_rst_flags"}, longint'({frame_done, overrun, overflow, sync_err}), 0);
    reset_n = 1'b1;
    clr_q();
  endtask

  task automatic wait_out(input string tag, input int n);
    for (int i = 0; i < 80 && q_re.size() < n; i++) tick();
    repeat (6) tick();
    check_eq({tag, "_count"}, q_re.size(), n);
  endtask

  task automatic expect_frame(input string tag, input int base, input longint re, input longint im,
                              input int bank);
    for (int i = 0; i < int'(TOTAL); i++) begin
      if (base + i < q_re.size()) begin
        check_eq($sformatf("%s_re%0d", tag, i), q_re[base+i], re);
        check_eq($sformatf("%s_im%0d", tag, i), q_im[base+i], im);
        check_eq($sformatf("%s_last%0d", tag, i), q_last[base+i], (i == int'(TOTAL) - 1) ? 1 : 0);
        check_eq($sformatf("%s_bank%0d", tag, i), q_bank[base+i], bank);
      end else begin
        check_eq($sformatf("%s_missing%0d", tag, i), q_re.size(), base + i + 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    bus.in_valid_i = 1'b0;
    bus.in_last_i = 1'b0;
    bus.in_re_i = '0;
    bus.in_im_i = '0;
    bus.out_ready_i = 1'b1;

    // 1: three blocks of (+1,-2) into one frame.
    do_reset("t1");
    cfg_count = 16'd3;
    send_frame(3, 1, -2);
    wait_out("t1", 4);
    expect_frame("t1", 0, 3, -6, 0);
    check_eq("t1_frame_done", fd_cnt, 1);

    // 2: same frame read with out_ready toggling, then bank 0 must be reusable.
    do_reset("t2");
    cfg_count = 16'd3;
    send_frame(3, 1, -2);
    for (int i = 0; i < 60 && q_re.size() < 4; i++) begin
      bus.out_ready_i = ~bus.out_ready_i;
      tick();
    end
    bus.out_ready_i = 1'b1;
    repeat (6) tick();
    check_eq("t2_count", q_re.size(), 4);
    expect_frame("t2", 0, 3, -6, 0);
    cfg_count = 16'd1;
    send_frame(1, 1, -2);
    send_frame(1, 1, -2);
    wait_out("t2b", 12);
    expect_frame("t2b1", 4, 1, -2, 1);
    expect_frame("t2b0", 8, 1, -2, 0);
    check_eq("t2_overrun", longint'(overrun), 0);

    // 3: wrapping then saturating accumulation of +63 over four blocks.
    do_reset("t3");
    cfg_count = 16'd4;
    send_frame(4, 63, -1);
    wait_out("t3w", 4);
    expect_frame("t3w", 0, -4, -4, 0);
    check_eq("t3w_overflow", longint'(overflow), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("t3_clear", longint'(overflow), 0);
    cfg_sat = 1'b1;
    send_frame(4, 63, -1);
    wait_out("t3s", 8);
    expect_frame("t3s", 4, 127, -4, 1);
    check_eq("t3s_overflow", longint'(overflow), 1);

    // 4: overrun with the output stalled, then drain and re-arm.
    do_reset("t4");
    cfg_count = 16'd1;
    bus.out_ready_i = 1'b0;
    send_frame(3, 1, -2);
    repeat (6) tick();
    check_eq("t4_frame_done", fd_cnt, 2);
    check_eq("t4_overrun", longint'(overrun), 1);
    check_eq("t4_no_output", q_re.size(), 0);
    check_eq("t4_valid_held", longint'(bus.out_valid_o), 1);
    bus.out_ready_i = 1'b1;
    wait_out("t4", 8);
    expect_frame("t4b0", 0, 1, -2, 0);
    expect_frame("t4b1", 4, 1, -2, 1);
    if (q_cyc.size() >= 8) check_eq("t4_back_to_back", q_cyc[7] - q_cyc[0], 7);
    else check_eq("t4_back_to_back_missing", q_cyc.size(), 8);
    send_frame(1, 2, 3);
    wait_out("t4n", 12);
    expect_frame("t4n", 8, 2, 3, 0);
    check_eq("t4_frame_done_total", fd_cnt, 3);

    // 5: framing errors (early last, missing last with clear in the same cycle), then a clean frame.
    do_reset("t5");
    cfg_count = 16'd2;
    send(9, 9, 1'b0);
    send(9, 9, 1'b0);
    send(9, 9, 1'b1);
    check_eq("t5_early_last", longint'(sync_err), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("t5_clear", longint'(sync_err), 0);
    send(9, 9, 1'b0);
    send(9, 9, 1'b0);
    send(9, 9, 1'b0);
    clear = 1'b1;
    send(9, 9, 1'b0);
    clear = 1'b0;
    check_eq("t5_missing_last_vs_clear", longint'(sync_err), 1);
    send_frame(2, 5, -7);
    wait_out("t5", 4);
    expect_frame("t5", 0, 10, -14, 0);
    check_eq("t5_frame_done", fd_cnt, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("t5_clear_end", longint'(sync_err), 0);

    // 6: reset while a bank is being read and another is half written.
    do_reset("t6");
    cfg_count = 16'd2;
    bus.out_ready_i = 1'b0;
    send(1, 1, 1'b1);
    send_frame(2, 1, -2);
    for (int i = 0; i < 20 && !bus.out_valid_o; i++) tick();
    check_eq("t6_pre_valid", longint'(bus.out_valid_o), 1);
    send(1, 1, 1'b0);
    send(1, 1, 1'b0);
    check_eq("t6_pre_sync_err", longint'(sync_err), 1);
    reset_n = 1'b0;
    tick();
    check_eq("t6_rst_valid", longint'(bus.out_valid_o), 0);
    check_eq("t6_rst_data", longint'(cur), 0);
    check_eq("t6_rst_flags", longint'({frame_done, overrun, overflow, sync_err}), 0);
    reset_n = 1'b1;
    clr_q();
    bus.out_ready_i = 1'b1;
    send_frame(2, 3, 1);
    wait_out("t6", 4);
    expect_frame("t6", 0, 6, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vis_bank_accumulator.md
Name: vis_bank_accumulator

Overview:
- Parametrised successor to the single-pass visibility output store.
- Accumulates per-block partial visibilities (TOTAL entries per block, signed SBITS re/im) over a runtime-programmable number of blocks into ACCUM-bit sums.
- Uses a BANKS-deep ring of banked RAM, and streams completed frames out over an AXI4-Stream-style port on vis_clock.
- Sits between the partial-sum accumulator chain and the bus-side CDC FIFO. Adds overrun handling, framing checks and an optional saturating mode.

Parameters:
TOTAL, 540, entries per block (CORES*TRATE); must be >= 3
SBITS, 7, width of signed partial-sum inputs
ACCUM, 36, width of signed accumulated visibilities
BANKS, 2, number of frame banks (>= 2)
NBITS, 16, width of block-count configuration

Ports:
vis_clock  in  1  clock
reset_n  in  1  synchronous, active-low reset
cfg_count_i  in  NBITS  blocks per frame; sampled at frame start; 0 treated as 1
cfg_sat_i  in  1  1 = saturating add, 0 = wrapping add; sampled at frame start
clear_i  in  1  clears sticky flags
in_valid_i  in  1  partial-sum entry valid (no backpressure)
in_last_i  in  1  last entry of block
in_re_i  in  SBITS  signed real partial sum
in_im_i  in  SBITS  signed imag partial sum
out_valid_o  out  1  output entry valid
out_ready_i  in  1  downstream ready
out_last_o  out  1  last entry of frame (index TOTAL-1)
out_re_o  out  ACCUM  accumulated real
out_im_o  out  ACCUM  accumulated imag
out_bank_o  out  $clog2(BANKS)  bank being streamed
frame_done_o  out  1  one-cycle pulse when a bank becomes full
overrun_o  out  1  sticky: input dropped, no free bank
overflow_o  out  1  sticky: any add exceeded ACCUM range
sync_err_o  out  1  sticky: in_last_i misaligned with entry TOTAL-1

Behaviour:
- Reset: all outputs 0, all banks empty, write bank 0, entry address 0, block count 0, read idle. Reset mid-stream abandons all frames and clears all state.
- Write side, address and block counting:
  - Entry address advances 0..TOTAL-1 on each accepted in_valid_i.
  - The block counter advances when the entry at TOTAL-1 is accepted with in_last_i=1.
- Write side, first block of a frame: the sign-extended input is written directly, with no read.
- Write side, later blocks: 3-stage read-modify-write (read RAM at accept, add next cycle, write the cycle after). Sequential addressing with TOTAL >= 3 means no hazard; no forwarding is required.
- Arithmetic:
  - Sum = old + sign_extend(in). overflow_o is set on signed overflow of either re or im.
  - If cfg_sat_i=1, clamp to +(2^(ACCUM-1)-1) / -(2^(ACCUM-1)); otherwise wrap.
- Frame completion: when block count reaches cfg_count_i, the bank is marked full one cycle after its final write lands, frame_done_o pulses for 1 cycle, and the writer moves to the next bank (mod BANKS).
- Framing error:
  - Trigger: in_last_i at address != TOTAL-1, or address TOTAL-1 accepted without in_last_i.
  - Response: sync_err_o set, current frame aborted, writer restarts at block 0, address 0 in the same bank; the next entry is treated as the first entry of a first block.
- Overrun:
  - If the next write bank is still full or being read, entries are discarded and overrun_o is set.
  - The writer re-arms only at a block boundary (the entry after an in_last_i) once a bank is free, starting a fresh frame.
- Read side:
  - The oldest full bank is streamed at addresses 0..TOTAL-1. out_valid_o rises at most 3 cycles after the bank is marked full.
  - Handshake on out_valid_o & out_ready_i. Data, last and bank stay stable while out_valid_o & !out_ready_i.
  - Sustained throughput is 1 entry/cycle with out_ready_i held high, using a prefetch/skid register to hide 1-cycle RAM latency.
  - out_last_o=1 only on entry TOTAL-1. The bank is freed the cycle after that handshake, and the next full bank (if any) follows without an idle cycle.
- Simultaneous events:
  - A bank freed in the same cycle the writer needs it counts as free (no overrun).
  - clear_i in the same cycle as a new flag event leaves the flag set.

Test Plan:
1. TOTAL=4, BANKS=2, cfg_count_i=3, every entry re=+1/im=-2, 12 entries with in_last_i every 4th -> frame_done_o pulses once; out stream re=3, im=-6 on 4 entries, out_last_o on 4th, out_bank_o=0.
2. Same, with out_ready_i toggling 1/0 every cycle -> out values stable while stalled; exactly 4 handshakes; bank 0 freed after the 4th.
3. ACCUM=8, cfg_count_i=4, re=+63 -> cfg_sat_i=0 gives re=252 wrapped (-4), overflow_o=1; cfg_sat_i=1 gives re=127, overflow_o=1.
4. out_ready_i=0, 3 frames sent with cfg_count_i=1 -> banks 0 and 1 full, third frame dropped, overrun_o=1; release out_ready_i -> frames from banks 0 then 1 delivered, then a new frame accepted at the next block boundary.
5. in_last_i asserted on entry 2 of 4 -> sync_err_o=1, frame restarts; the subsequent clean frame outputs the correct sums; clear_i drops sync_err_o.
6. Assert reset_n=0 mid-frame and mid-readout -> all outputs 0 next cycle; the next frame after reset accumulates from zero.
